// File: rtl/matrix_stack_if.sv
// ---------------------------------------------------------------------------
// matrix_stack_if
//   Command/data bundle between the geometry front end and matrix_stack_ctrl.
//   master : front end (drives commands, push rows and load matrices)
//   slave  : matrix_stack_ctrl (returns popped rows, top peek, depth, flags)
// Signals
//   matrix_mode  stack select            data_out    popped row stream
//   push_en      push command            data_valid  data_out holds a row
//   pop_en       pop command             peek_out    top of selected stack
//   write_en     one-cycle load          depth_out   saved count of selected stack
//   data_in      push row stream         busy        push/pop in progress
//   write_in     full matrix for load    overflow / underflow / cmd_err pulses
// ---------------------------------------------------------------------------
interface matrix_stack_if #(
  parameter int ROWS   = 4,
  parameter int DEPTH  = 8,
  parameter int MODE_W = 2
);
  localparam int ROW_W = ROWS * 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [MODE_W-1:0]      matrix_mode;
  logic                   push_en;
  logic                   pop_en;
  logic                   write_en;
  logic [ROW_W-1:0]       data_in;
  logic [ROWS*ROW_W-1:0]  write_in;
  logic [ROW_W-1:0]       data_out;
  logic                   data_valid;
  logic [ROWS*ROW_W-1:0]  peek_out;
  logic [CNT_W-1:0]       depth_out;
  logic                   busy;
  logic                   overflow;
  logic                   underflow;
  logic                   cmd_err;

  modport master (
    output matrix_mode, push_en, pop_en, write_en, data_in, write_in,
    input  data_out, data_valid, peek_out, depth_out, busy,
           overflow, underflow, cmd_err
  );

  modport slave (
    input  matrix_mode, push_en, pop_en, write_en, data_in, write_in,
    output data_out, data_valid, peek_out, depth_out, busy,
           overflow, underflow, cmd_err
  );
endinterface

// File: rtl/matrix_stack_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_stack_ctrl
//   Multi-mode matrix stack (modelview/projection/texture). Each mode keeps a
//   top matrix plus a LIFO of DEPTH saved matrices. Push saves the top and
//   loads a new one row-serially from data_in; pop restores the saved matrix
//   and streams the discarded top out on data_out, one row per cycle. Load
//   replaces the top in a single cycle.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (tops -> identity, counts -> 0)
//   bus  matrix_stack_if.slave (commands, row streams, peek/depth, flags)
// ---------------------------------------------------------------------------
module matrix_stack_ctrl #(
  parameter int ROWS      = 4,
  parameter int DEPTH     = 8,
  parameter int NUM_MODES = 2,
  parameter int MODE_W    = 2
) (
  input  logic clk,
  input  logic rst,
  matrix_stack_if.slave bus
);
  localparam int ROW_W = ROWS * 32;
  localparam int MAT_W = ROWS * ROW_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;

  state_t            state_q, state_d;
  logic [MAT_W-1:0]  top_q  [NUM_MODES];
  logic [MAT_W-1:0]  lifo_q [NUM_MODES][DEPTH];
  logic [CNT_W-1:0]  cnt_q  [NUM_MODES];
  logic [MAT_W-1:0]  shadow_q;
  logic [MODE_W-1:0] mode_q;
  logic [RC_W-1:0]   rc_q;
  logic [ROW_W-1:0]  data_out_q;
  logic              data_valid_q, overflow_q, underflow_q, cmd_err_q;

  // Selected-mode view of the live matrix_mode (peek/depth and command decode)
  logic              mode_ok;
  logic [CNT_W-1:0]  sel_cnt;
  logic [MAT_W-1:0]  sel_top, sel_lifo;

  logic do_push, do_pop, do_write, ovf_d, udf_d, err_d;

  function automatic logic [MAT_W-1:0] identity();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) m[r*ROW_W + r*32 +: 32] = 32'h3F80_0000;
    return m;
  endfunction

  // Mode/depth lookups are loops with explicit compares so an out-of-range
  // matrix_mode simply matches nothing instead of indexing past the arrays.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    mode_ok  = 1'b0;
    sel_cnt  = '0;
    sel_top  = '0;
    sel_lifo = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (MODE_W'(m) == bus.matrix_mode) begin
        mode_ok = 1'b1;
        sel_cnt = cnt_q[m];
        sel_top = top_q[m];
        for (int d = 0; d < DEPTH; d++)
          if (CNT_W'(d) == cnt_q[m] - CNT_W'(1)) sel_lifo = lifo_q[m][d];
      end
    end
  end

  // FSM next-state and command decode; commands are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_write = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.push_en || bus.pop_en || bus.write_en) begin
          if (!mode_ok || (bus.push_en && bus.pop_en)) begin
            err_d = 1'b1;
          end else if (bus.push_en) begin
            if (sel_cnt == CNT_W'(DEPTH)) ovf_d = 1'b1;
            else begin
              do_push = 1'b1;
              state_d = (ROWS > 1) ? PUSH : IDLE;
            end
          end else if (bus.pop_en) begin
            if (sel_cnt == '0) udf_d = 1'b1;
            else begin
              do_pop  = 1'b1;
              state_d = (ROWS > 1) ? POP : IDLE;
            end
          end else begin
            do_write = 1'b1;
          end
        end
      end
      PUSH, POP: if (rc_q == RC_W'(ROWS - 1)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        top_q[m] <= identity();
        cnt_q[m] <= '0;
      end
      mode_q       <= '0;
      rc_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      overflow_q   <= ovf_d;
      underflow_q  <= udf_d;
      cmd_err_q    <= err_d;
      data_valid_q <= 1'b0;

      if (do_push || do_pop) begin
        mode_q <= bus.matrix_mode;
        rc_q   <= RC_W'(1);
      end else if (state_q != IDLE) begin
        rc_q <= rc_q + RC_W'(1);
      end

      for (int m = 0; m < NUM_MODES; m++) begin
        if (MODE_W'(m) == bus.matrix_mode) begin
          if (do_push) begin
            cnt_q[m]            <= cnt_q[m] + CNT_W'(1);
            top_q[m][0 +: ROW_W] <= bus.data_in;
          end
          if (do_pop) begin
            cnt_q[m] <= cnt_q[m] - CNT_W'(1);
            top_q[m] <= sel_lifo;
          end
          if (do_write) top_q[m] <= bus.write_in;
        end
        // Remaining push rows go to the mode latched at accept
        if (state_q == PUSH && MODE_W'(m) == mode_q)
          top_q[m][rc_q*ROW_W +: ROW_W] <= bus.data_in;
      end

      if (do_pop) begin
        data_out_q   <= sel_top[0 +: ROW_W];
        data_valid_q <= 1'b1;
      end else if (state_q == POP) begin
        data_out_q   <= shadow_q[rc_q*ROW_W +: ROW_W];
        data_valid_q <= 1'b1;
      end
    end
  end

  // NOTE: the LIFO storage and pop shadow are deliberately not reset; the
  // per-mode counts gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_pop) shadow_q <= sel_top;
    for (int m = 0; m < NUM_MODES; m++)
      for (int d = 0; d < DEPTH; d++)
        if (do_push && MODE_W'(m) == bus.matrix_mode && CNT_W'(d) == sel_cnt)
          lifo_q[m][d] <= sel_top;
  end

  assign bus.peek_out   = sel_top;
  assign bus.depth_out  = sel_cnt;
  assign bus.busy       = (state_q != IDLE);
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_matrix_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_stack_ctrl
//   Directed and randomized stimulus for matrix_stack_ctrl. A queue-based
//   reference model holds each mode's top and saved matrices; expected popped
//   rows and flag pulses go into queues that a negedge monitor drains.
// ---------------------------------------------------------------------------
module tb_matrix_stack_ctrl;
  localparam int ROWS      = 4;
  localparam int DEPTH     = 8;
  localparam int NUM_MODES = 2;
  localparam int MODE_W    = 2;
  localparam int ROW_W     = ROWS * 32;
  localparam int MAT_W     = ROWS * ROW_W;

  typedef logic [MAT_W-1:0] mat_t;
  typedef logic [ROW_W-1:0] row_t;

  localparam int OP_PUSH = 0, OP_POP = 1, OP_WRITE = 2, OP_BOTH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_stack_if #(.ROWS(ROWS), .DEPTH(DEPTH), .MODE_W(MODE_W)) bus ();

  matrix_stack_ctrl #(
    .ROWS(ROWS), .DEPTH(DEPTH), .NUM_MODES(NUM_MODES), .MODE_W(MODE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model
  mat_t        m_top   [NUM_MODES];
  mat_t        m_stack [NUM_MODES][$];
  row_t        exp_rows[$];
  logic [2:0]  exp_flags[$];   // {overflow, underflow, cmd_err}

  int errors = 0;
  int checks = 0;

  function automatic mat_t ident();
    mat_t m = '0;
    for (int r = 0; r < ROWS; r++) m[r*ROW_W + r*32 +: 32] = 32'h3F80_0000;
    return m;
  endfunction

  function automatic row_t row_of(mat_t m, int r);
    return m[r*ROW_W +: ROW_W];
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int w = 0; w < MAT_W / 32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic check(string name, logic [MAT_W-1:0] act, logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NUM_MODES; m++) begin
      m_top[m] = ident();
      m_stack[m].delete();
    end
  endtask

  task automatic clear_cmds();
    bus.push_en  = 1'b0;
    bus.pop_en   = 1'b0;
    bus.write_en = 1'b0;
  endtask

  // Compare every mode's top and depth with the model while idle
  task automatic settle_check(string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    for (int m = 0; m < NUM_MODES; m++) begin
      bus.matrix_mode = MODE_W'(m);
      #1;
      check({tag, "_peek"}, bus.peek_out, m_top[m]);
      check({tag, "_depth"}, bus.depth_out, m_stack[m].size());
    end
  endtask

  // Issue one command (inputs change 1 ns after a rising edge)
  task automatic cmd(int op, int mode, mat_t mat);
    bit accepted = 1'b0;
    bus.matrix_mode = MODE_W'(mode);
    bus.push_en     = (op == OP_PUSH) || (op == OP_BOTH);
    bus.pop_en      = (op == OP_POP)  || (op == OP_BOTH);
    bus.write_en    = (op == OP_WRITE) || (op == OP_BOTH && $urandom_range(0, 1) == 1);
    bus.data_in     = row_of(mat, 0);
    bus.write_in    = mat;

    if (mode >= NUM_MODES || op == OP_BOTH) begin
      exp_flags.push_back(3'b001);
    end else if (op == OP_PUSH) begin
      if (m_stack[mode].size() == DEPTH) exp_flags.push_back(3'b100);
      else begin
        m_stack[mode].push_back(m_top[mode]);
        m_top[mode] = mat;
        accepted = 1'b1;
      end
    end else if (op == OP_POP) begin
      if (m_stack[mode].size() == 0) exp_flags.push_back(3'b010);
      else begin
        for (int r = 0; r < ROWS; r++) exp_rows.push_back(row_of(m_top[mode], r));
        m_top[mode] = m_stack[mode].pop_back();
        accepted = 1'b1;
      end
    end else begin
      m_top[mode] = mat;
    end

    @(posedge clk); #1;
    clear_cmds();
    if (accepted) begin
      for (int r = 1; r < ROWS; r++) begin
        check("busy_during_cmd", bus.busy, 1'b1);
        bus.data_in = (op == OP_PUSH) ? row_of(mat, r) : row_t'({$urandom, $urandom, $urandom, $urandom});
        // Commands and mode wiggle while busy must have no effect
        bus.matrix_mode = MODE_W'($urandom_range(0, 3));
        bus.push_en     = $urandom_range(0, 1) == 1;
        bus.pop_en      = $urandom_range(0, 1) == 1;
        bus.write_en    = $urandom_range(0, 1) == 1;
        bus.write_in    = rand_mat();
        @(posedge clk); #1;
      end
      clear_cmds();
    end
    check("busy_after_cmd", bus.busy, 1'b0);
  endtask

  // Monitor: drains expected rows and flag pulses whenever the DUT shows one
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.data_valid) begin
          if (exp_rows.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_row: got %0h expected no row", bus.data_out);
          end else begin
            check("pop_row", bus.data_out, exp_rows.pop_front());
          end
        end
        if ({bus.overflow, bus.underflow, bus.cmd_err} != 3'b000) begin
          if (exp_flags.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_flag: got %b expected none",
                     {bus.overflow, bus.underflow, bus.cmd_err});
          end else begin
            check("flag", {bus.overflow, bus.underflow, bus.cmd_err}, exp_flags.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t rowmat;
    row_t r0;
    rst = 1'b1;
    bus.matrix_mode = '0;
    bus.data_in     = '0;
    bus.write_in    = '0;
    clear_cmds();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    bus.matrix_mode = '0;
    #1;
    r0 = 128'h00000000_00000000_00000000_3F800000;
    check("reset_row0", bus.peek_out[ROW_W-1:0], r0);
    check("reset_valid", bus.data_valid, 1'b0);
    check("reset_data_out", bus.data_out, '0);
    check("reset_flags", {bus.overflow, bus.underflow, bus.cmd_err}, 3'b000);
    settle_check("reset");

    // Push four equal rows, then pop them back
    rowmat = {ROWS{128'h3F800000400000004040000040800000}};
    cmd(OP_PUSH, 0, rowmat);
    settle_check("push0");
    cmd(OP_POP, 0, '0);
    settle_check("pop0");

    // Underflow, then fill to overflow
    cmd(OP_POP, 0, '0);
    settle_check("underflow");
    for (int i = 0; i <= DEPTH; i++) cmd(OP_PUSH, 0, rand_mat());
    settle_check("overflow");

    // Illegal combinations and single-cycle load
    cmd(OP_BOTH, 0, rand_mat());
    cmd(OP_WRITE, 1, rand_mat());
    settle_check("write1");
    cmd(OP_WRITE, 3, rand_mat());
    cmd(OP_PUSH, 2, rand_mat());
    settle_check("bad_mode");

    // Randomized mix, back-to-back
    for (int i = 0; i < 300; i++) begin
      int op, mode;
      op   = ($urandom_range(0, 19) == 0) ? OP_BOTH : $urandom_range(0, 2);
      mode = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NUM_MODES - 1);
      cmd(op, mode, rand_mat());
      if (i % 25 == 0) settle_check("random");
    end
    settle_check("random_end");
    repeat (ROWS + 2) @(posedge clk);
    #1;

    // Reset in the middle of a push
    bus.matrix_mode = '0;
    bus.push_en     = 1'b1;
    bus.data_in     = 128'h1;
    @(posedge clk); #1;
    clear_cmds();
    bus.data_in = 128'h2;
    @(posedge clk); #1;
    bus.data_in = 128'h3;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("midreset_busy", bus.busy, 1'b0);
    bus.matrix_mode = '0;
    #1;
    check("midreset_peek", bus.peek_out, ident());
    check("midreset_depth", bus.depth_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    settle_check("after_reset");

    repeat (3) @(posedge clk);
    check("rows_pending", exp_rows.size(), 0);
    check("flags_pending", exp_flags.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
